regfile_scoreboard: RTL and testbench

Parametrised decode-stage register file with a built-in scoreboard and write-through bypass, succeeding the fixed 32x32 negedge-written file with externally supplied forwarding selects. It sits in the ID stage between fetch and execute. It supplies both source operands, tracks in-flight destination registers, and raises a stall whenever a source or destination has a write still pending. Multiple writeback ports (ALU, MEM, return-address) write on the rising edge; same-cycle writes reach the read ports through an internal bypass.

---
 rtl/regfile_scoreboard.sv | 101 ++++++++++
 tb/tb_regfile_scoreboard.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with multi-port writeback, same-cycle bypass and a
// pending-write scoreboard that stalls issue on RAW/WAW hazards.
module regfile_scoreboard #(
  parameter int NB_WORD    = 32,
  parameter int NB_OPERAND = 5,
  parameter int N_WR       = 3
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic [NB_OPERAND-1:0]        i_rs1,
  input  logic [NB_OPERAND-1:0]        i_rs2,
  input  logic                         i_rs1_used,
  input  logic                         i_rs2_used,
  input  logic                         i_issue_valid,
  input  logic                         i_issue_wr,
  input  logic [NB_OPERAND-1:0]        i_issue_rd,
  input  logic [N_WR-1:0]              i_wr_en,
  input  logic [N_WR*NB_OPERAND-1:0]   i_wr_addr,
  input  logic [N_WR*NB_WORD-1:0]      i_wr_data,
  output logic [NB_WORD-1:0]           o_op1,
  output logic [NB_WORD-1:0]           o_op2,
  output logic                         o_stall,
  output logic                         o_issue_ack,
  output logic [(2**NB_OPERAND)-1:0]   o_pend_mask
);

  localparam int NREG = 2**NB_OPERAND;

  logic [NB_WORD-1:0] regs [NREG];
  logic [NREG-1:0]    pend;
  logic [NREG-1:0]    clr_mask;
  logic [NREG-1:0]    set_mask;
  logic               hit1, hit2, hit_rd;
  logic               raw1, raw2, waw;

  // Ascending port scan: a later (higher-index) match overrides, giving it priority.
  always_comb begin
    o_op1    = regs[i_rs1];
    o_op2    = regs[i_rs2];
    hit1     = 1'b0;
    hit2     = 1'b0;
    hit_rd   = 1'b0;
    clr_mask = '0;
    for (int p = 0; p < N_WR; p++) begin
      if (i_wr_en[p]) begin
        if (i_wr_addr[p*NB_OPERAND +: NB_OPERAND] == i_rs1) begin
          o_op1 = i_wr_data[p*NB_WORD +: NB_WORD];
          hit1  = 1'b1;
        end
        if (i_wr_addr[p*NB_OPERAND +: NB_OPERAND] == i_rs2) begin
          o_op2 = i_wr_data[p*NB_WORD +: NB_WORD];
          hit2  = 1'b1;
        end
        if (i_wr_addr[p*NB_OPERAND +: NB_OPERAND] == i_issue_rd) hit_rd = 1'b1;
        clr_mask[i_wr_addr[p*NB_OPERAND +: NB_OPERAND]] = 1'b1;
      end
    end
    if (i_rs1 == '0) begin
      o_op1 = '0;
      hit1  = 1'b0;
    end
    if (i_rs2 == '0) begin
      o_op2 = '0;
      hit2  = 1'b0;
    end
    if (i_issue_rd == '0) hit_rd = 1'b0;
    clr_mask[0] = 1'b0;
  end

  // Issue handshake: i_issue_valid offers an instruction, o_issue_ack accepts it
  // in the same cycle; a stalled instruction is held and re-presented unchanged.
  always_comb begin
    raw1        = i_rs1_used & pend[i_rs1] & ~hit1;
    raw2        = i_rs2_used & pend[i_rs2] & ~hit2;
    waw         = i_issue_wr & pend[i_issue_rd] & ~hit_rd;
    o_stall     = i_issue_valid & (raw1 | raw2 | waw);
    o_issue_ack = i_issue_valid & ~o_stall;
    set_mask    = '0;
    if (o_issue_ack && i_issue_wr && (i_issue_rd != '0)) set_mask[i_issue_rd] = 1'b1;
  end

  // A new issue to rd overrides a same-cycle writeback clear of rd.
  always_ff @(posedge i_clock) begin
    if (i_reset) pend <= '0;
    else         pend <= (pend & ~clr_mask) | set_mask;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int p = 0; p < N_WR; p++) begin
        if (i_wr_en[p] && (i_wr_addr[p*NB_OPERAND +: NB_OPERAND] != '0))
          regs[i_wr_addr[p*NB_OPERAND +: NB_OPERAND]] <= i_wr_data[p*NB_WORD +: NB_WORD];
      end
    end
  end

  assign o_pend_mask = pend;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios then random traffic, checked
// every cycle against an array-based reference model of the register file.
module tb_regfile_scoreboard;

  localparam int W  = 32;
  localparam int A  = 5;
  localparam int NW = 3;
  localparam int NR = 32;

  logic            clk;
  logic            reset;
  logic [A-1:0]    rs1, rs2, rd;
  logic            rs1_used, rs2_used, issue_valid, issue_wr;
  logic [NW-1:0]   wr_en;
  logic [NW*A-1:0] wr_addr;
  logic [NW*W-1:0] wr_data;
  logic [W-1:0]    op1, op2;
  logic            stall, ack;
  logic [NR-1:0]   pend_mask;

  // reference model state
  logic [W-1:0]    model_r [NR];
  logic [NR-1:0]   model_pend;
  logic [W-1:0]    exp_q [$];
  logic            exp_ack_now;

  int n_checks = 0;
  int n_pass   = 0;

  regfile_scoreboard #(.NB_WORD(W), .NB_OPERAND(A), .N_WR(NW)) dut (
    .i_clock(clk), .i_reset(reset),
    .i_rs1(rs1), .i_rs2(rs2), .i_rs1_used(rs1_used), .i_rs2_used(rs2_used),
    .i_issue_valid(issue_valid), .i_issue_wr(issue_wr), .i_issue_rd(rd),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_op1(op1), .o_op2(op2), .o_stall(stall), .o_issue_ack(ack),
    .o_pend_mask(pend_mask)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // ---- reference model ----
  function automatic logic wb_hit(input logic [A-1:0] a);
    if (a == 0) return 1'b0;
    for (int p = 0; p < NW; p++)
      if (wr_en[p] && wr_addr[p*A +: A] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] model_read(input logic [A-1:0] a);
    if (a == 0) return '0;
    for (int p = NW-1; p >= 0; p--)
      if (wr_en[p] && wr_addr[p*A +: A] == a) return wr_data[p*W +: W];
    return model_r[a];
  endfunction

  function automatic logic model_stall();
    logic hazard;
    hazard = (rs1_used && model_pend[rs1] && !wb_hit(rs1)) ||
             (rs2_used && model_pend[rs2] && !wb_hit(rs2)) ||
             (issue_wr && model_pend[rd]  && !wb_hit(rd));
    return issue_valid && hazard;
  endfunction

  task automatic model_clock();
    if (reset) begin
      for (int i = 0; i < NR; i++) model_r[i] = '0;
      model_pend = '0;
    end else begin
      for (int p = 0; p < NW; p++)
        if (wr_en[p] && wr_addr[p*A +: A] != 0) begin
          model_r[wr_addr[p*A +: A]] = wr_data[p*W +: W];
          model_pend[wr_addr[p*A +: A]] = 1'b0;
        end
      if (exp_ack_now && issue_wr && rd != 0) model_pend[rd] = 1'b1;
    end
  endtask

  // ---- driver tasks ----
  task automatic idle();
    rs1 = '0; rs2 = '0; rs1_used = 0; rs2_used = 0;
    issue_valid = 0; issue_wr = 0; rd = '0;
    wr_en = '0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic set_wr(input int p, input logic [A-1:0] a, input logic [W-1:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*A +: A] = a;
    wr_data[p*W +: W] = d;
  endtask

  task automatic present(input logic v, input logic w, input logic [A-1:0] d,
                         input logic u1, input logic [A-1:0] s1,
                         input logic u2, input logic [A-1:0] s2);
    issue_valid = v; issue_wr = w; rd = d;
    rs1_used = u1; rs1 = s1; rs2_used = u2; rs2 = s2;
  endtask

  // scoreboard: compare all outputs against the model, away from the edge
  task automatic settle();
    logic s;
    #2;
    s = model_stall();
    exp_ack_now = issue_valid && !s;
    exp_q.push_back(model_read(rs1));
    exp_q.push_back(model_read(rs2));
    check("op1", op1, exp_q.pop_front());
    check("op2", op2, exp_q.pop_front());
    check("stall", stall, s);
    check("ack", ack, exp_ack_now);
    check("pend_mask", pend_mask, model_pend);
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    exp_ack_now = 1'b0;
    model_pend = '0;
    for (int i = 0; i < NR; i++) model_r[i] = '0;
    @(posedge clk); #1;

    // reset then read
    repeat (2) begin settle(); tick(); end
    reset = 1'b0;
    present(1, 0, 0, 1, 5, 1, 31);
    settle();
    check("rst_op1", op1, 0);
    check("rst_op2", op2, 0);
    check("rst_stall", stall, 0);
    check("rst_pend", pend_mask, 0);
    tick();

    // bypass priority
    idle(); set_wr(0, 7, 32'h11); set_wr(2, 7, 32'h22); rs1 = 7;
    settle(); check("bypass_same", op1, 32'h22); tick();
    idle(); rs1 = 7;
    settle(); check("bypass_next", op1, 32'h22); tick();

    // x0 guard
    idle(); set_wr(0, 0, 32'hDEAD); present(1, 1, 0, 1, 0, 0, 0);
    settle(); check("x0_op1", op1, 0); check("x0_stall", stall, 0); tick();
    idle(); rs1 = 0;
    settle(); check("x0_op1_next", op1, 0); check("x0_pend0", pend_mask[0], 0); tick();

    // RAW stall then release through bypass
    idle(); present(1, 1, 3, 0, 0, 0, 0);
    settle(); check("raw_issue_ack", ack, 1); tick();
    idle(); present(1, 0, 0, 1, 3, 0, 0);
    settle(); check("raw_stall_1", stall, 1); tick();
    settle(); check("raw_stall_2", stall, 1); tick();
    set_wr(1, 3, 32'h5A);
    settle(); check("raw_release", stall, 0); check("raw_ack", ack, 1);
    check("raw_op1", op1, 32'h5A); tick();
    idle();
    settle(); check("raw_pend_clr", pend_mask[3], 0); tick();

    // WAW with simultaneous set/clear
    present(1, 1, 9, 0, 0, 0, 0);
    settle(); tick();
    settle(); check("waw_stall", stall, 1); tick();
    set_wr(0, 9, 32'h99);
    settle(); check("waw_ack", ack, 1); tick();
    idle();
    settle(); check("waw_pend_kept", pend_mask[9], 1); tick();
    set_wr(2, 9, 32'h9A); settle(); tick(); idle();

    // reset mid-flight
    set_wr(0, 4, 32'h1234); settle(); tick();
    idle(); present(1, 1, 4, 0, 0, 0, 0); settle(); tick();
    present(1, 1, 12, 0, 0, 0, 0); settle();
    check("mid_pend4", pend_mask[4], 1); tick();
    idle(); reset = 1'b1; settle(); tick();
    reset = 1'b0;
    present(1, 0, 0, 1, 4, 0, 0);
    settle(); check("mid_pend", pend_mask, 0); check("mid_r4", op1, 0);
    check("mid_stall", stall, 0); tick();

    // random traffic on a small address window to provoke hazards
    for (int c = 0; c < 400; c++) begin
      idle();
      reset = ($urandom_range(0, 59) == 0);
      present($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
              $urandom_range(0, 1), $urandom_range(0, 7),
              $urandom_range(0, 1), $urandom_range(0, 7));
      for (int p = 0; p < NW; p++)
        if ($urandom_range(0, 2) == 0) set_wr(p, $urandom_range(0, 7), $urandom);
      settle();
      tick();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
